// File: rtl/sr_pulse_gen_if.sv
// sr_pulse_gen_if: level inputs and pulse/level outputs of sr_pulse_gen
// Ports: ena (debounce enable), d (raw levels) from master;
//        s/r (set/reset pulses), q/nq (filtered level and inverse) from slave.
interface sr_pulse_gen_if #(parameter int WIDTH = 1);
  logic ena;
  logic [WIDTH-1:0] d, s, r, q, nq;
  modport master (output ena, d, input s, r, q, nq);
  modport slave (input ena, d, output s, r, q, nq);
endinterface

// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen: synchronize, debounce and turn level inputs into one-cycle set/reset pulses
// Ports: clk (rising edge), nrst (async active-low reset),
//        bus.ena/bus.d in; bus.s/bus.r pulses, bus.q filtered level, bus.nq = ~q out.
module sr_pulse_gen #(
  parameter int WIDTH = 1,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter logic INIT_LEVEL = 1'b0
) (
  input logic clk,
  input logic nrst,
  sr_pulse_gen_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] INIT = {WIDTH{INIT_LEVEL}};
  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [WIDTH-1:0] y, q, s, r, diff, hit;
  logic [CW-1:0] cnt [WIDTH];
  logic [CW-1:0] cnt_n [WIDTH];
  assign y = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= INIT;
    end else begin
      sync[0] <= bus.d;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
    end
  // The flip happens on the edge that would take the count to DEBOUNCE_CYCLES,
  // so the counter clears instead of ever reaching or wrapping past it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    assign diff[i] = y[i] ^ q[i];
    assign hit[i] = bus.ena & diff[i] & (cnt[i] == LAST);
    assign cnt_n[i] = (!diff[i] || hit[i]) ? '0 : bus.ena ? cnt[i] + CW'(1) : cnt[i];
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      q <= INIT;
      s <= '0;
      r <= '0;
      cnt <= '{default: '0};
    end else begin
      q <= q ^ hit;
      s <= hit & ~q;
      r <= hit & q;
      cnt <= cnt_n;
    end
  assign bus.q = q;
  assign bus.nq = ~q;
  assign bus.s = s;
  assign bus.r = r;
endmodule

// File: tb/tb_sr_pulse_gen.sv
// tb_sr_pulse_gen: directed and randomized checks of sr_pulse_gen against a run-length model
module tb_sr_pulse_gen;
  localparam int W = 4;
  localparam int D = 4;
  localparam logic [W-1:0] ALL = '1;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  sr_pulse_gen_if #(.WIDTH(W)) bus ();
  sr_pulse_gen_if #(.WIDTH(1)) bus1 ();
  sr_pulse_gen #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(D), .INIT_LEVEL(1'b0))
    u_dut (.clk(clk), .nrst(nrst), .bus(bus));
  sr_pulse_gen #(.WIDTH(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .INIT_LEVEL(1'b0))
    u_fast (.clk(clk), .nrst(nrst), .bus(bus1));
  always #5 clk = ~clk;

  // Model: the input reaches the debouncer two edges late; q flips once the
  // delayed input has disagreed with q for D enabled samples in a row.
  logic [W-1:0] m_h0, m_h1, m_q, m_s, m_r;
  int m_run [W];
  function automatic int run_next(logic y, logic q, int run, logic en);
    return (y == q) ? 0 : en ? run + 1 : run;
  endfunction
  always @(posedge clk or negedge nrst)
    if (!nrst) begin
      m_h0 <= '0;
      m_h1 <= '0;
      m_q <= '0;
      m_s <= '0;
      m_r <= '0;
      for (int i = 0; i < W; i++) m_run[i] <= 0;
    end else begin
      m_h0 <= bus.d;
      m_h1 <= m_h0;
      for (int i = 0; i < W; i++) begin
        m_run[i] <= run_next(m_h1[i], m_q[i], m_run[i], bus.ena) % D;
        m_q[i] <= m_q[i] ^ (run_next(m_h1[i], m_q[i], m_run[i], bus.ena) == D);
        m_s[i] <= (run_next(m_h1[i], m_q[i], m_run[i], bus.ena) == D) && !m_q[i];
        m_r[i] <= (run_next(m_h1[i], m_q[i], m_run[i], bus.ena) == D) && m_q[i];
      end
    end

  task automatic test_reset();
    logic [W-1:0] es, eq;
    nrst = 1'b0;
    bus.d = ALL;
    bus.ena = 1'b1;
    bus1.d = 1'b0;
    bus1.ena = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.q, bus.nq, bus.s, bus.r} !== {4'h0, ALL, 4'h0, 4'h0}) begin
        n_bad++;
        $display("FAIL reset_hold c=%0d got q/nq/s/r=%b/%b/%b/%b want 0000/1111/0000/0000", c, bus.q, bus.nq, bus.s, bus.r);
      end
    end
    nrst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      es = (c == 5) ? ALL : 4'h0;
      eq = (c >= 5) ? ALL : 4'h0;
      n_cmp++;
      if ({bus.q, bus.nq, bus.s, bus.r} !== {eq, ~eq, es, 4'h0}) begin
        n_bad++;
        $display("FAIL reset_release c=%0d got q/nq/s/r=%b/%b/%b/%b want %b/%b/%b/0000", c, bus.q, bus.nq, bus.s, bus.r, eq, ~eq, es);
      end
    end
  endtask

  task automatic test_clean_edges();
    logic [W-1:0] es, er, eq;
    for (int p = 0; p < 2; p++) begin
      bus.d = (p == 0) ? 4'h0 : ALL;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        es = (p == 1 && c == 5) ? ALL : 4'h0;
        er = (p == 0 && c == 5) ? ALL : 4'h0;
        eq = ((c >= 5) == (p == 1)) ? ALL : 4'h0;
        n_cmp++;
        if ({bus.q, bus.nq, bus.s, bus.r} !== {eq, ~eq, es, er}) begin
          n_bad++;
          $display("FAIL clean_edge p=%0d c=%0d got q/nq/s/r=%b/%b/%b/%b want %b/%b/%b/%b", p, c, bus.q, bus.nq, bus.s, bus.r, eq, ~eq, es, er);
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [W-1:0] er, eq;
    for (int c = 0; c < 15; c++) begin
      bus.d = (c < 3) ? 4'h0 : ALL;
      @(negedge clk);
      n_cmp++;
      if ({bus.q, bus.s, bus.r} !== {ALL, 4'h0, 4'h0}) begin
        n_bad++;
        $display("FAIL glitch_short c=%0d got q/s/r=%b/%b/%b want 1111/0000/0000", c, bus.q, bus.s, bus.r);
      end
    end
    for (int c = 0; c < 20; c++) begin
      bus.d = (c == 3) ? ALL : 4'h0;
      @(negedge clk);
      er = (c == 9) ? ALL : 4'h0;
      eq = (c >= 9) ? 4'h0 : ALL;
      n_cmp++;
      if ({bus.q, bus.s, bus.r} !== {eq, 4'h0, er}) begin
        n_bad++;
        $display("FAIL glitch_bounce c=%0d got q/s/r=%b/%b/%b want %b/0000/%b", c, bus.q, bus.s, bus.r, eq, er);
      end
    end
  endtask

  task automatic test_ena();
    logic [W-1:0] es, eq;
    bus.d = ALL;
    for (int c = 0; c < 16; c++) begin
      bus.ena = !(c >= 4 && c < 9);
      @(negedge clk);
      es = (c == 10) ? ALL : 4'h0;
      eq = (c >= 10) ? ALL : 4'h0;
      n_cmp++;
      if ({bus.q, bus.s, bus.r} !== {eq, es, 4'h0}) begin
        n_bad++;
        $display("FAIL ena_gate c=%0d got q/s/r=%b/%b/%b want %b/%b/0000", c, bus.q, bus.s, bus.r, eq, es);
      end
    end
    bus.ena = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] es, eq;
    bus.d = 4'h0;
    for (int c = 0; c < 5; c++) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.q, bus.nq, bus.s, bus.r} !== {4'h0, ALL, 4'h0, 4'h0}) begin
      n_bad++;
      $display("FAIL async_clear got q/nq/s/r=%b/%b/%b/%b want 0000/1111/0000/0000", bus.q, bus.nq, bus.s, bus.r);
    end
    bus.d = ALL;
    @(negedge clk);
    nrst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      es = (c == 5) ? ALL : 4'h0;
      eq = (c >= 5) ? ALL : 4'h0;
      n_cmp++;
      if ({bus.q, bus.s, bus.r} !== {eq, es, 4'h0}) begin
        n_bad++;
        $display("FAIL async_relatch c=%0d got q/s/r=%b/%b/%b want %b/%b/0000", c, bus.q, bus.s, bus.r, eq, es);
      end
    end
  endtask

  task automatic test_multi();
    logic [W-1:0] es, er, eq;
    bus.d = 4'h0;
    for (int c = 0; c < 10; c++) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      bus.d = (p == 0) ? 4'b0101 : 4'b1010;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        es = (c == 5) ? bus.d : 4'h0;
        er = (p == 1 && c == 5) ? 4'b0101 : 4'h0;
        eq = (c >= 5) ? bus.d : (p == 0) ? 4'h0 : 4'b0101;
        n_cmp++;
        if ({bus.q, bus.s, bus.r} !== {eq, es, er}) begin
          n_bad++;
          $display("FAIL multi p=%0d c=%0d got q/s/r=%b/%b/%b want %b/%b/%b", p, c, bus.q, bus.s, bus.r, eq, es, er);
        end
      end
    end
  endtask

  task automatic test_debounce_one();
    logic dv [204];
    for (int c = 0; c < 204; c++) begin
      dv[c] = (c < 4) ? 1'b0 : 1'($urandom);
      bus1.d = dv[c];
      @(negedge clk);
      if (c >= 4) begin
        n_cmp++;
        if ({bus1.q, bus1.s, bus1.r} !== {dv[c-2], dv[c-2] & ~dv[c-3], ~dv[c-2] & dv[c-3]}) begin
          n_bad++;
          $display("FAIL debounce_one c=%0d got q/s/r=%b/%b/%b want %b/%b/%b", c, bus1.q, bus1.s, bus1.r, dv[c-2], dv[c-2] & ~dv[c-3], ~dv[c-2] & dv[c-3]);
        end
      end
    end
  endtask

  task automatic test_random();
    int hold [W];
    logic [W-1:0] nd;
    for (int i = 0; i < W; i++) hold[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      nrst = 1'b1;
      nd = bus.d;
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          nd[i] = 1'($urandom);
          hold[i] = $urandom_range(1, 7);
        end
        hold[i]--;
      end
      bus.d = nd;
      bus.ena = ($urandom_range(0, 9) != 0);
      @(negedge clk);
      n_cmp++;
      if ({bus.q, bus.nq, bus.s, bus.r} !== {m_q, ~m_q, m_s, m_r}) begin
        n_bad++;
        $display("FAIL random c=%0d got q/nq/s/r=%b/%b/%b/%b want %b/%b/%b/%b", c, bus.q, bus.nq, bus.s, bus.r, m_q, ~m_q, m_s, m_r);
      end
      n_cmp++;
      if ((bus.s & bus.r) !== 4'h0) begin
        n_bad++;
        $display("FAIL s_and_r c=%0d got s&r=%b want 0000", c, bus.s & bus.r);
      end
      if ($urandom_range(0, 249) == 0) begin
        #2 nrst = 1'b0;
        @(negedge clk);
      end
    end
    nrst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_edges();
    test_glitch();
    test_ena();
    test_async_reset();
    test_multi();
    test_debounce_one();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sr_pulse_gen.md
Name: sr_pulse_gen

Overview:
- Converts asynchronous level inputs into clean, single-cycle set/reset pulse pairs. These pulses are the natural drivers for the synchronous SR triggers used across the design.
- Per channel: a synchronizer chain, a debounce counter and a filtered-level register. One clock-wide `s` pulse is produced per qualified rising edge, and one clock-wide `r` pulse per qualified falling edge.
- Sits between board-level inputs (buttons, status lines from other clock domains) and control logic that consumes set/reset events.

Parameters:
- WIDTH, 1, number of independent channels.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive synchronized samples that must differ from the filtered level before it flips; legal range 1..65535.
- INIT_LEVEL, 0, reset value of every filtered level and of every synchronizer stage.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- nrst  input  1  asynchronous active-low reset.
- ena  input  1  debounce enable; when low, counters and levels hold.
- d  input  WIDTH  raw asynchronous level inputs.
- s  output  WIDTH  one-cycle set pulse per channel on a qualified rising edge.
- r  output  WIDTH  one-cycle reset pulse per channel on a qualified falling edge.
- q  output  WIDTH  filtered, debounced level.
- nq  output  WIDTH  bitwise inverse of q.

Behaviour:
- Reset and clocking:
  - One clock. Reset is asynchronous and active-low (nrst): it asserts immediately and deasserts synchronously to clk through the external reset synchronizer.
  - During reset: all synchronizer stages = INIT_LEVEL, q = INIT_LEVEL for all bits, nq = ~INIT_LEVEL, s = 0, r = 0, all counters = 0.
  - Reset mid-debounce discards the partial count. No pulse is emitted on reset assertion or release.
- Synchronizer: d[i] passes through SYNC_STAGES registers. The last stage is y[i]. The synchronizer runs regardless of ena.
- Per-channel counter:
  - Width is ceil(log2(DEBOUNCE_CYCLES+1)), minimum 1 bit.
  - If ena = 1, y[i] != q[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] increments.
  - If ena = 1, y[i] != q[i] and cnt[i] == DEBOUNCE_CYCLES-1: on that edge q[i] toggles and cnt[i] clears to 0. s[i] = 1 if the new q[i] is 1, otherwise r[i] = 1.
  - If y[i] == q[i]: cnt[i] clears to 0, regardless of ena.
  - If ena = 0: cnt[i] holds. q, s and r do not change except that s/r return to 0.
- Pulses:
  - s and r are registered and high for exactly one clock.
  - s[i] and r[i] are never high in the same cycle.
  - The next opposite pulse is at least DEBOUNCE_CYCLES clocks later.
- Latency: a clean input change that is stable before rising edge E0 produces the pulse and the new q after edge E(SYNC_STAGES+DEBOUNCE_CYCLES-1). That is SYNC_STAGES+DEBOUNCE_CYCLES edges total; with defaults, visible after the 6th edge.
- Glitch rejection:
  - Any y[i] excursion shorter than DEBOUNCE_CYCLES consecutive samples produces no pulse, and q[i] is unchanged.
  - A bounce resets the count; counting is not cumulative.
- Channels are fully independent. Simultaneous events on different bits pulse in the same cycle.
- nq is combinational ~q.
- Counter arithmetic never wraps: saturation is impossible because the count clears at DEBOUNCE_CYCLES-1.
- DEBOUNCE_CYCLES = 1: q follows y with one edge of delay and a pulse on every change of y.

Test Plan:
- Reset check: hold nrst = 0 with d = 1 for 10 cycles (INIT_LEVEL = 0) -> q = 0, nq = 1, s = r = 0 throughout. Release nrst -> s[0] = 1 exactly once, on the 6th edge after the first active edge; q = 1 from then on.
- Clean edges: defaults, WIDTH = 1, d 0->1, wait 20 cycles, d 1->0 -> s pulses for 1 cycle 6 edges after the rise, r pulses for 1 cycle 6 edges after the fall. q tracks accordingly and nq = ~q always.
- Glitch rejection: d = 1 for 3 cycles then 0 (DEBOUNCE_CYCLES = 4) -> no s, q stays 0. Bounce 1,1,1,0,1,1,1,1 -> single s, 4 counted samples after the last 0.
- ena gating: during a rising debounce at cnt = 2, drop ena for 5 cycles then raise it -> q holds 0 while ena = 0. s fires 2 edges after ena returns (cnt resumes 2->3->flip).
- Async reset mid-operation: assert nrst between clock edges at cnt = 3 -> q, s, r and cnt clear immediately without a clock. After release with d still 1, a full 6-edge latency is required before s.
- Multi-channel: WIDTH = 4, d = 4'b0101 then 4'b1010 after settling -> s = 0101 in one cycle. Then, after the 4'b1010 step settles, s = 1010 and r = 0101 in the same cycle. s & r == 0 is asserted every cycle.
